decoder: RTL and testbench
==========================

// Module: decoder
// PURPOSE
//  Inverse of the encoder: turns a token-id sequence back into a byte string.
//  - Reads token ids from an input RAM.
//  - Finds each id's byte string in the vocab RAM: strings separated by SEP, vocab end marked by END_MARK.
//  - Writes the decoded bytes sequentially to an output RAM, then raises done.
// PARAMETERS
//  ADDR_WIDTH  4      address width of token, vocab and output RAMs (depth 2**ADDR_WIDTH)
//  DATA_WIDTH  8      byte/token-id width
//  SEP         8'h00  vocab string separator; token k = k-th string, counting from 0
//  END_MARK    8'hFF  vocab terminator; reaching it = unknown token
// PORTS
//  clk         in   1            clock, rising edge
//  rst         in   1            asynchronous reset, active-high
//  cs          in   1            chip select: 1 starts/holds a run, 0 aborts/clears
//  n_tokens    in   ADDR_WIDTH+1 number of tokens to decode (0..2**ADDR_WIDTH); sampled at start
//  tok_addr    out  ADDR_WIDTH   token RAM read address
//  tok_data    in   DATA_WIDTH   token RAM read data, valid 1 cycle after tok_addr
//  vocab_addr  out  ADDR_WIDTH   vocab RAM read address
//  vocab_data  in   DATA_WIDTH   vocab RAM read data, valid 1 cycle after vocab_addr
//  out_addr    out  ADDR_WIDTH   output RAM write address
//  out_data    out  DATA_WIDTH   output RAM write data
//  out_we      out  1            output RAM write strobe, one byte per high cycle
//  out_len     out  ADDR_WIDTH+1 bytes written so far; final length when done=1
//  done        out  1            run finished successfully; held until cs=0
//  err         out  1            run failed; held until cs=0
// BEHAVIOUR
//  Reset:
//  - All outputs 0; state IDLE.
//  - Async assert, including mid-run; no further writes after reset asserts.
//  RAMs are synchronous: data for address A is consumed on the cycle after A is driven.
//  FSM states:
//  - IDLE:  cs=1 -> latch n_tokens, tok index=0, out_len=0.
//           n_tokens==0 -> DONE, else FETCH.
//  - FETCH: drive tok_addr=index; next cycle register tok_data as target id.
//           Clear separator count; vocab_addr=0 -> SEEK.
//  - SEEK:  step vocab_addr by 1 per cycle, inspecting returned byte.
//           SEP -> count++; count==target -> COPY, starting at the next address.
//           target==0 -> COPY immediately at address 0.
//           END_MARK -> ERR.
//  - COPY:  each non-SEP, non-END_MARK byte -> out_we=1, out_addr=out_len[ADDR_WIDTH-1:0],
//           out_data=byte; out_len++ on the same edge.
//           SEP or END_MARK ends the string -> index++; index==n_tokens -> DONE, else FETCH.
//           Empty string (SEP immediately) writes nothing and is legal.
//  - DONE:  done=1, out_we=0; stay until cs=0 -> IDLE (done cleared).
//  - ERR:   err=1, out_we=0; stay until cs=0 -> IDLE (err cleared).
//           Output RAM holds bytes written before the error.
//  Boundaries:
//  - vocab_addr at 2**ADDR_WIDTH-1 and next byte still needed -> ERR (no wrap).
//  - Write needed when out_len==2**ADDR_WIDTH (output full) -> ERR, no write.
//  - Exactly filling the output is legal.
//  - cs=0 in any state -> IDLE next cycle, out_we=0 that cycle, done/err cleared.
//    out_len holds its last value until the next start.
//  - Speculative vocab reads past the string end are allowed; they never write.
//  Widths:
//  - index and out_len are ADDR_WIDTH+1 bits; no wrap; compared unsigned.
// TESTING
//  1 vocab "a\0bc\0d\0\xFF", tokens {1,0,2}, n=3, cs=1
//    -> output "bca d"-free: bytes 'b','c','a','d', out_len=4, done=1, err=0
//  2 n_tokens=0, cs=1 -> done=1 within 2 cycles, out_we never asserted, out_len=0
//  3 vocab "a\0\xFF", token {5} -> err=1, done=0, no writes; cs=0 -> err=0 next cycle
//  4 16 tokens each decoding to 1 byte, then a 17th byte needed
//    -> 16 writes at addr 0..15, then err=1
//  5 rst pulse during COPY of a 3-byte token -> all outputs 0 immediately, no further
//    writes; restart decodes correctly
//  6 cs dropped mid-SEEK -> IDLE next cycle, no writes; cs=1 again -> full correct run

Source files
------------

// File: rtl/decoder.sv
// -----------------------------------------------------------------------------
// decoder
//   Turns a sequence of token ids back into a byte string. Each token id is
//   read from a token RAM. The matching string is then located in a vocab RAM,
//   where strings are separated by SEP and the table ends at END_MARK. The
//   string's bytes are written one per cycle to an output RAM. done is raised
//   when every token has been decoded. err is raised on an unknown token, on
//   running off the vocab RAM, or on overflowing the output RAM.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   cs                 1 starts/holds a run, 0 aborts and returns to IDLE
//   n_tokens           number of tokens to decode, sampled at start
//   tok_addr/tok_data  token RAM read port (data one cycle after address)
//   vocab_addr/_data   vocab RAM read port (data one cycle after address)
//   out_addr/_data/_we output RAM write port
//   out_len            bytes written so far (final length when done)
//   done, err          terminal status, held until cs drops
// -----------------------------------------------------------------------------
module decoder #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SEP        = '0,
  parameter logic [DATA_WIDTH-1:0] END_MARK   = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic [ADDR_WIDTH:0]   n_tokens,
  output logic [ADDR_WIDTH-1:0] tok_addr,
  input  logic [DATA_WIDTH-1:0] tok_data,
  output logic [ADDR_WIDTH-1:0] vocab_addr,
  input  logic [DATA_WIDTH-1:0] vocab_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_we,
  output logic [ADDR_WIDTH:0]   out_len,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH:0]   OUT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,   // token address on the bus
    S_LOAD,    // token id arrives; vocab address 0 on the bus
    S_SEEK,    // skipping strings until the target one starts
    S_COPY,    // writing bytes of the target string
    S_DONE,
    S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   n_q, n_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  // vaddr_q is the address currently driven; daddr_q is the address whose
  // data is on vocab_data this cycle (the one driven a cycle earlier).
  logic [ADDR_WIDTH-1:0] vaddr_q, vaddr_d;
  logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;

  logic                  we;
  logic                  last_byte;
  logic                  is_sep;
  logic                  is_end;
  logic [DATA_WIDTH-1:0] cnt_inc;
  logic [ADDR_WIDTH:0]   idx_inc;

  assign last_byte = (daddr_q == ADDR_MAX);
  assign is_sep    = (vocab_data == SEP);
  assign is_end    = (vocab_data == END_MARK);
  assign cnt_inc   = cnt_q + 1'b1;
  assign idx_inc   = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    idx_d    = idx_q;
    len_d    = len_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    vaddr_d  = vaddr_q;
    daddr_d  = daddr_q;
    we       = 1'b0;

    if (!cs) begin
      // Abort from anywhere; out_len is deliberately left untouched.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          n_d     = n_tokens;
          idx_d   = '0;
          len_d   = '0;
          state_d = (n_tokens == '0) ? S_DONE : S_FETCH;
        end

        S_FETCH: begin
          vaddr_d = '0;
          state_d = S_LOAD;
        end

        S_LOAD: begin
          target_d = tok_data;
          cnt_d    = '0;
          daddr_d  = vaddr_q;
          vaddr_d  = vaddr_q + 1'b1;
          // Token 0 is the first string, so copying starts at address 0.
          state_d  = (tok_data == '0) ? S_COPY : S_SEEK;
        end

        S_SEEK: begin
          if (is_end || last_byte) begin
            // Unknown token, or the next byte would lie past the vocab RAM.
            state_d = S_ERR;
          end else begin
            daddr_d = vaddr_q;
            if (vaddr_q != ADDR_MAX) vaddr_d = vaddr_q + 1'b1;
            if (is_sep) begin
              cnt_d = cnt_inc;
              if (cnt_inc == target_q) state_d = S_COPY;
            end
          end
        end

        S_COPY: begin
          if (is_sep || is_end) begin
            idx_d   = idx_inc;
            state_d = (idx_inc == n_q) ? S_DONE : S_FETCH;
          end else if (len_q == OUT_FULL) begin
            state_d = S_ERR;
          end else begin
            we    = 1'b1;
            len_d = len_q + 1'b1;
            // The terminator of this string would be beyond the vocab RAM.
            if (last_byte) begin
              state_d = S_ERR;
            end else begin
              daddr_d = vaddr_q;
              if (vaddr_q != ADDR_MAX) vaddr_d = vaddr_q + 1'b1;
            end
          end
        end

        S_DONE:  state_d = S_DONE;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      vaddr_q  <= '0;
      daddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      vaddr_q  <= vaddr_d;
      daddr_q  <= daddr_d;
    end
  end

  assign tok_addr   = idx_q[ADDR_WIDTH-1:0];
  assign vocab_addr = vaddr_q;
  assign out_we     = we;
  assign out_addr   = we ? len_q[ADDR_WIDTH-1:0] : '0;
  assign out_data   = we ? vocab_data : '0;
  assign out_len    = len_q;
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);

endmodule

// File: tb/tb_decoder.sv
// -----------------------------------------------------------------------------
// tb_decoder
//   Bench for decoder. Token, vocab and output RAMs are modelled with
//   registered reads. A string-level reference decoder pushes every expected
//   write (address, byte) into a queue. A negedge monitor pops the queue and
//   compares each real write against it.
// -----------------------------------------------------------------------------
module tb_decoder;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs;
  logic [AW:0]   n_tokens;
  logic [AW-1:0] tok_addr;
  logic [DW-1:0] tok_data;
  logic [AW-1:0] vocab_addr;
  logic [DW-1:0] vocab_data;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_we;
  logic [AW:0]   out_len;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  decoder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEP(8'h00), .END_MARK(8'hFF)
  ) dut (
    .clk(clk), .rst(rst), .cs(cs), .n_tokens(n_tokens),
    .tok_addr(tok_addr), .tok_data(tok_data),
    .vocab_addr(vocab_addr), .vocab_data(vocab_data),
    .out_addr(out_addr), .out_data(out_data), .out_we(out_we),
    .out_len(out_len), .done(done), .err(err)
  );

  logic [7:0] tok_mem   [16];
  logic [7:0] vocab_mem [16];
  logic [7:0] out_mem   [16];

  always @(posedge clk) begin
    tok_data   <= tok_mem[tok_addr];
    vocab_data <= vocab_mem[vocab_addr];
    if (out_we) out_mem[out_addr] <= out_data;
  end

  logic [AW+DW-1:0] sb [$];
  int n_vec    = 0;
  int n_miss   = 0;
  int n_writes = 0;

  always @(negedge clk) begin
    logic [AW+DW-1:0] exp_w;
    if (out_we === 1'b1) begin
      n_writes++;
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL write_unexpected: got addr=%0d data=%02h, required no write", out_addr, out_data);
      end else begin
        exp_w = sb.pop_front();
        if ({out_addr, out_data} !== exp_w) begin
          n_miss++;
          $display("FAIL write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                   out_addr, out_data, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
        end else begin
          $display("write addr=%0d data=%02h ok", out_addr, out_data);
        end
      end
    end
  end

  task automatic clear_mems();
    for (int i = 0; i < 16; i++) begin
      tok_mem[i]   = 8'h00;
      vocab_mem[i] = 8'hFF;
    end
  endtask

  // Reference decoder working on whole strings: reading a byte beyond address
  // 15 is an error, as is writing a 17th output byte.
  task automatic build_expect(input int n, output bit e_err, output int e_len);
    int         a;
    int         cnt;
    int         t;
    int         len;
    logic [7:0] b;
    bit         stop;
    len   = 0;
    e_err = 1'b0;
    for (int k = 0; k < n && !e_err; k++) begin
      t = int'(tok_mem[k]);
      a = 0;
      if (t != 0) begin
        cnt  = 0;
        stop = 1'b0;
        while (!stop && !e_err) begin
          if (a > 15) e_err = 1'b1;
          else begin
            b = vocab_mem[a];
            a++;
            if (b == 8'hFF) e_err = 1'b1;
            else if (b == 8'h00) begin
              cnt++;
              if (cnt == t) stop = 1'b1;
            end
          end
        end
      end
      stop = 1'b0;
      while (!stop && !e_err) begin
        if (a > 15) e_err = 1'b1;
        else begin
          b = vocab_mem[a];
          a++;
          if (b == 8'h00 || b == 8'hFF) stop = 1'b1;
          else if (len == 16) e_err = 1'b1;
          else begin
            sb.push_back({4'(len), b});
            len++;
          end
        end
      end
    end
    e_len = len;
  endtask

  // Raise cs and wait (bounded) for done or err.
  task automatic start_and_wait(input int budget, output bit timed_out);
    cs        = 1'b1;
    timed_out = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (done || err) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b0; n_tokens = '0;
    clear_mems();
    for (int i = 0; i < 16; i++) out_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({tok_addr, vocab_addr, out_addr, out_data, out_we, out_len, done, err} !== '0) begin
      n_miss++;
      $display("FAIL reset_outputs: got we=%b len=%0d done=%b err=%b, required all 0", out_we, out_len, done, err);
    end else $display("reset outputs ok");
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit e_err, to; int e_len; logic [31:0] got, want;
    clear_mems();
    vocab_mem[0] = "a"; vocab_mem[1] = 8'h00; vocab_mem[2] = "b"; vocab_mem[3] = "c";
    vocab_mem[4] = 8'h00; vocab_mem[5] = "d"; vocab_mem[6] = 8'h00; vocab_mem[7] = 8'hFF;
    tok_mem[0] = 8'd1; tok_mem[1] = 8'd0; tok_mem[2] = 8'd2;
    n_tokens = 5'd3;
    build_expect(3, e_err, e_len);
    start_and_wait(200, to);
    n_vec++;
    if (to || done !== 1'b1 || err !== 1'b0 || out_len !== 5'(e_len) || sb.size() != 0) begin
      n_miss++;
      $display("FAIL basic: got to=%b done=%b err=%b len=%0d pending=%0d, required done=1 err=0 len=%0d pending=0",
               to, done, err, out_len, sb.size(), e_len);
    end else $display("basic run ok len=%0d", out_len);
    got  = {out_mem[0], out_mem[1], out_mem[2], out_mem[3]};
    want = "bcad";
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL basic_ram: got %08h, required %08h", got, want);
    end else $display("basic ram contents ok");
    cs = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0 || out_len !== 5'd4) begin
      n_miss++;
      $display("FAIL basic_clear: got done=%b len=%0d, required done=0 len=4", done, out_len);
    end else $display("basic clear ok, out_len held");
  endtask

  task automatic test_zero_tokens();
    bit to; int w0;
    n_tokens = '0;
    w0 = n_writes;
    start_and_wait(2, to);
    n_vec++;
    if (to || done !== 1'b1 || err !== 1'b0 || out_len !== '0 || n_writes != w0) begin
      n_miss++;
      $display("FAIL zero_tokens: got to=%b done=%b err=%b len=%0d writes=%0d, required done=1 err=0 len=0 writes=0",
               to, done, err, out_len, n_writes - w0);
    end else $display("zero tokens ok");
    cs = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unknown();
    bit e_err, to; int e_len, w0;
    clear_mems();
    vocab_mem[0] = "a"; vocab_mem[1] = 8'h00; vocab_mem[2] = 8'hFF;
    tok_mem[0] = 8'd5;
    n_tokens = 5'd1;
    w0 = n_writes;
    build_expect(1, e_err, e_len);
    start_and_wait(200, to);
    n_vec++;
    if (to || err !== e_err || done !== 1'b0 || n_writes != w0) begin
      n_miss++;
      $display("FAIL unknown: got to=%b err=%b done=%b writes=%0d, required err=%b done=0 writes=0",
               to, err, done, n_writes - w0, e_err);
    end else $display("unknown token err ok");
    cs = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (err !== 1'b0) begin
      n_miss++;
      $display("FAIL unknown_clear: got err=%b, required 0", err);
    end else $display("err cleared ok");
  endtask

  // 15 one-byte tokens and one two-byte token: 16 writes, then the 17th byte errors.
  task automatic test_output_full();
    bit e_err, to; int e_len, w0;
    clear_mems();
    vocab_mem[0] = "a"; vocab_mem[1] = 8'h00; vocab_mem[2] = "b"; vocab_mem[3] = "c";
    vocab_mem[4] = 8'h00; vocab_mem[5] = 8'hFF;
    for (int i = 0; i < 15; i++) tok_mem[i] = 8'd0;
    tok_mem[15] = 8'd1;
    n_tokens = 5'd16;
    w0 = n_writes;
    build_expect(16, e_err, e_len);
    start_and_wait(400, to);
    n_vec++;
    if (to || err !== e_err || done !== 1'b0 || n_writes - w0 != 16 || out_len !== 5'(e_len) || sb.size() != 0) begin
      n_miss++;
      $display("FAIL output_full: got to=%b err=%b writes=%0d len=%0d, required err=%b writes=16 len=%0d",
               to, err, n_writes - w0, out_len, e_err, e_len);
    end else $display("output full err ok");
    cs = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_exact_fill();
    bit e_err, to; int e_len;
    clear_mems();
    vocab_mem[0] = "q"; vocab_mem[1] = 8'h00; vocab_mem[2] = 8'hFF;
    n_tokens = 5'd16;
    build_expect(16, e_err, e_len);
    start_and_wait(400, to);
    n_vec++;
    if (to || done !== !e_err || err !== e_err || out_len !== 5'd16 || sb.size() != 0) begin
      n_miss++;
      $display("FAIL exact_fill: got to=%b done=%b err=%b len=%0d, required done=1 err=0 len=16", to, done, err, out_len);
    end else $display("exact fill ok");
    cs = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vocab_overflow();
    bit e_err, to; int e_len, w0;
    // Seeking runs off the end of the vocab RAM.
    clear_mems();
    for (int i = 0; i < 16; i++) vocab_mem[i] = "z";
    tok_mem[0] = 8'd1;
    n_tokens = 5'd1;
    w0 = n_writes;
    build_expect(1, e_err, e_len);
    start_and_wait(200, to);
    n_vec++;
    if (to || err !== e_err || n_writes != w0) begin
      n_miss++;
      $display("FAIL seek_overflow: got to=%b err=%b writes=%0d, required err=%b writes=0", to, err, n_writes - w0, e_err);
    end else $display("seek overflow err ok");
    cs = 1'b0;
    @(posedge clk); #1;
    // A string that reaches address 15 with no terminator: 15 writes then err.
    vocab_mem[0] = 8'h00;
    w0 = n_writes;
    build_expect(1, e_err, e_len);
    start_and_wait(200, to);
    n_vec++;
    if (to || err !== e_err || n_writes - w0 != e_len || e_len != 15 || sb.size() != 0) begin
      n_miss++;
      $display("FAIL copy_overflow: got to=%b err=%b writes=%0d, required err=%b writes=15", to, err, n_writes - w0, e_err);
    end else $display("copy overflow err ok");
    cs = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_copy();
    bit e_err, to, found; int e_len, w0; logic [23:0] got, want;
    clear_mems();
    vocab_mem[0] = "a"; vocab_mem[1] = "b"; vocab_mem[2] = "c"; vocab_mem[3] = 8'h00;
    tok_mem[0] = 8'd0;
    n_tokens = 5'd1;
    build_expect(1, e_err, e_len);
    cs = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #2;
      if (out_we && out_addr == 4'd1) begin
        found = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!found) begin
      n_miss++;
      $display("FAIL reset_copy_reach: got no second write within 50 cycles, required one");
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({tok_addr, vocab_addr, out_addr, out_data, out_we, out_len, done, err} !== '0) begin
      n_miss++;
      $display("FAIL reset_copy_outputs: got we=%b len=%0d done=%b err=%b, required all 0", out_we, out_len, done, err);
    end else $display("async reset mid copy ok");
    sb.delete();
    cs = 1'b0;
    w0 = n_writes;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (n_writes != w0) begin
      n_miss++;
      $display("FAIL reset_copy_nowrite: got %0d writes, required 0", n_writes - w0);
    end else $display("no writes after reset ok");
    build_expect(1, e_err, e_len);
    start_and_wait(200, to);
    got  = {out_mem[0], out_mem[1], out_mem[2]};
    want = "abc";
    n_vec++;
    if (to || done !== 1'b1 || out_len !== 5'(e_len) || sb.size() != 0 || got !== want) begin
      n_miss++;
      $display("FAIL reset_restart: got to=%b done=%b len=%0d ram=%06h, required done=1 len=%0d ram=%06h",
               to, done, out_len, got, e_len, want);
    end else $display("restart after reset ok");
    cs = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_cs_abort();
    bit e_err, to; int e_len, w0;
    clear_mems();
    vocab_mem[0] = "a"; vocab_mem[1] = 8'h00; vocab_mem[2] = "b"; vocab_mem[3] = "c";
    vocab_mem[4] = 8'h00; vocab_mem[5] = "d"; vocab_mem[6] = 8'h00; vocab_mem[7] = 8'hFF;
    tok_mem[0] = 8'd2;
    n_tokens = 5'd1;
    w0 = n_writes;
    cs = 1'b1;
    // IDLE, FETCH, LOAD, then seeking through the first bytes.
    repeat (4) @(posedge clk);
    #1;
    cs = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (out_we !== 1'b0 || done !== 1'b0 || err !== 1'b0 || n_writes != w0) begin
      n_miss++;
      $display("FAIL cs_abort: got we=%b done=%b err=%b writes=%0d, required all 0", out_we, done, err, n_writes - w0);
    end else $display("cs abort mid seek ok");
    build_expect(1, e_err, e_len);
    start_and_wait(200, to);
    n_vec++;
    if (to || done !== 1'b1 || out_len !== 5'(e_len) || sb.size() != 0 || out_mem[0] !== "d") begin
      n_miss++;
      $display("FAIL cs_rerun: got to=%b done=%b len=%0d ram0=%02h, required done=1 len=%0d ram0=64",
               to, done, out_len, out_mem[0], e_len);
    end else $display("rerun after abort ok");
    cs = 1'b0;
    @(posedge clk); #1;
  endtask

  // Two runs with no reset between; includes an empty vocab string.
  task automatic test_back_to_back();
    bit e_err, to; int e_len;
    clear_mems();
    vocab_mem[0] = "x"; vocab_mem[1] = "y"; vocab_mem[2] = 8'h00; vocab_mem[3] = 8'h00;
    vocab_mem[4] = "p"; vocab_mem[5] = "q"; vocab_mem[6] = 8'h00; vocab_mem[7] = 8'hFF;
    tok_mem[0] = 8'd1; tok_mem[1] = 8'd2; tok_mem[2] = 8'd0; tok_mem[3] = 8'd2;
    for (int r = 0; r < 2; r++) begin
      n_tokens = (r == 0) ? 5'd4 : 5'd2;
      build_expect(int'(n_tokens), e_err, e_len);
      start_and_wait(300, to);
      n_vec++;
      if (to || done !== !e_err || err !== e_err || out_len !== 5'(e_len) || sb.size() != 0) begin
        n_miss++;
        $display("FAIL back_to_back%0d: got to=%b done=%b err=%b len=%0d, required done=%b len=%0d",
                 r, to, done, err, out_len, !e_err, e_len);
      end else $display("back to back run %0d ok len=%0d", r, out_len);
      cs = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_tokens();
    test_unknown();
    test_output_full();
    test_exact_fill();
    test_vocab_overflow();
    test_reset_mid_copy();
    test_cs_abort();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
